ofm_write_scheduler: RTL and testbench
======================================

Name: ofm_write_scheduler

Overview:
Layer-level sequencer for the conv/maxpool output path. It runs each filter group through row windows and column tiles. For each window it starts a systolic compute pass, waits for completion, then issues the write burst that drives the OFM address controller (write pulse plus per-channel write enables). It also supplies count_filter to that controller and reports layer completion.

Parameters:
SYSTOLIC_SIZE, 16, systolic array dimension; column tile width is SYSTOLIC_SIZE/2.
OFM_SIZE, 32, output feature map height/width.
STRIDE, 2, 1 or 2; selects the column tiling rule.
ADDR_WIDTH, 14, kept for package consistency; unused internally.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle layer start; ignored while busy
wgt_size  in  5  filters per group (channels per write burst); latched at start
num_groups  in  7  number of filter groups in the layer; latched at start
compute_done  in  1  one-cycle pulse from systolic array: window result ready
compute_start  out  1  one-cycle pulse: begin compute of current window
write  out  1  one-cycle pulse to OFM address controller: start burst
ofm_wr_en  out  1  high for each channel beat of a burst
channel_idx  out  5  channel index of current beat
count_filter  out  7  current group index + 1
row_cnt  out  9  current output row within tile, 0..OFM_SIZE-1
tile_cnt  out  5  current column tile
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when the last burst of the last group retires

Behaviour:
- Reset: every output is 0, all counters are 0, FSM is IDLE. Reset takes effect immediately, including mid-burst.
- COL_TILES = ceil(OFM_SIZE/(SYSTOLIC_SIZE/2)) when STRIDE==2, else 1. This is an elaboration-time constant.
- Loop order: row_cnt innermost (0..OFM_SIZE-1), then tile_cnt, then group index outermost.
- Latched wgt_size==0 is treated as 1.
- FSM states: IDLE, COMPUTE, WAIT_DONE, WRITE, SETTLE, FINISH.
  - IDLE: start=1 latches config and clears counters. If latched num_groups==0, go to FINISH. Otherwise go to COMPUTE.
  - COMPUTE: compute_start=1 for exactly one cycle, then WAIT_DONE.
  - WAIT_DONE: stay until compute_done=1, then go to WRITE. compute_done in any other state is ignored.
  - WRITE: lasts wgt_size_l cycles. write=1 only in the first cycle. ofm_wr_en=1 in every cycle. channel_idx runs 0..wgt_size_l-1. After the last beat, go to SETTLE.
  - SETTLE: exactly 2 cycles with no writes, so the address controller can do its base-address update and return to idle. Then advance counters: row wraps and carries into tile; tile wraps and carries into group. If the last group is complete, go to FINISH; otherwise go to COMPUTE.
  - FINISH: done=1 for one cycle, busy drops the same cycle, then IDLE.
- Write-burst period (first write pulse to next write pulse) is wgt_size_l + 2 cycles plus compute latency.
- count_filter = group+1 throughout each group. It is stable from before the first write of the group until after its last SETTLE.
- row_cnt, tile_cnt and count_filter are registered and change only in the last SETTLE cycle.
- start while busy: ignored, with no effect on latched config.
- Counter widths: group counter is 7 bits. Compare against num_groups_l-1; no wrap past 127.

Decomposition:
- Shared package holds:
  - FSM state encoding
  - COL_TILES calculation function
  - tile width constant SYSTOLIC_SIZE/2
- One sub-module, sched_loop_counter: a nested row/tile/group counter with advance input and last/wrap flags. The FSM sits in the top module.

Test Plan:
- Defaults (OFM 32, SYS 16, STRIDE 2), wgt_size=4, num_groups=1, compute_done 3 cycles after each compute_start -> 128 write pulses and 512 ofm_wr_en beats; done pulses once; count_filter stays 1.
- OFM_SIZE=4, SYSTOLIC_SIZE=4, wgt_size=3, num_groups=2 -> 16 bursts. Rows cycle 0..3 within tiles 0..1. count_filter is 1 for bursts 1-8 and 2 for bursts 9-16. Spacing between write pulses is exactly 5 cycles plus compute latency.
- wgt_size=0, num_groups=1 (small config) -> each burst has exactly one beat with channel_idx=0.
- num_groups=0 -> done asserted 2 cycles after start; no compute_start and no write.
- start re-asserted mid-layer plus spurious compute_done during WRITE -> both ignored; burst count and sequence unchanged.
- rst_n dropped during WRITE beat 2 -> all outputs 0 asynchronously. A new start after release runs a clean layer from row 0, tile 0, group 1.

Source files
------------

// File: rtl/ofm_write_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ofm_write_scheduler_pkg
//  Purpose  : Shared types and elaboration helpers for the OFM write
//             scheduler. Holds the FSM state encoding, counter widths and the
//             column-tile helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package ofm_write_scheduler_pkg;

  localparam int ROW_W   = 9;
  localparam int TILE_W  = 5;
  localparam int GROUP_W = 7;
  localparam int WSZ_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COMPUTE   = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_WRITE     = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_FINISH    = 3'd5
  } sched_state_e;

  // Column tile width: half the systolic array, never less than 1.
  function automatic int tile_width(input int sys_size);
    return (sys_size / 2 < 1) ? 1 : sys_size / 2;
  endfunction

  // Only stride-2 layers are split into column tiles.
  function automatic int col_tiles(input int ofm_size, input int sys_size,
                                   input int stride);
    int tw;
    tw = tile_width(sys_size);
    if (stride == 2) begin
      return (ofm_size + tw - 1) / tw;
    end
    return 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ofm_write_scheduler_loop_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sched_loop_counter
//  Purpose  : Nested row / column-tile / filter-group counter. Row is the
//             innermost loop, group the outermost. count_filter is kept as
//             its own register (group + 1) so it is glitch-free downstream.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             clear_i             - restart at row 0, tile 0, group 0
//             advance_i           - step to the next window
//             num_groups_i        - latched group count (non-zero when used)
//             row_o / tile_o      - current row and column tile
//             count_filter_o      - current group index + 1
//             row_wrap_o          - row is at its last value
//             tile_wrap_o         - row and tile are both at their last value
//             last_o              - current window is the final one of layer
//  Revision : 1.0 - initial release
// ============================================================================
module sched_loop_counter
  import ofm_write_scheduler_pkg::*;
#(
  parameter int ROWS  = 32,
  parameter int TILES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               advance_i,
  input  logic [GROUP_W-1:0] num_groups_i,
  output logic [ROW_W-1:0]   row_o,
  output logic [TILE_W-1:0]  tile_o,
  output logic [GROUP_W-1:0] count_filter_o,
  output logic               row_wrap_o,
  output logic               tile_wrap_o,
  output logic               last_o
);

  localparam logic [ROW_W-1:0]  c_ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [TILE_W-1:0] c_TILE_LAST = TILE_W'(TILES - 1);

  logic [ROW_W-1:0]   row_q,   row_d;
  logic [TILE_W-1:0]  tile_q,  tile_d;
  logic [GROUP_W-1:0] group_q, group_d;
  logic [GROUP_W-1:0] cf_q,    cf_d;

  logic w_row_wrap;
  logic w_tile_wrap;
  logic w_group_last;

  assign w_row_wrap   = (row_q == c_ROW_LAST);
  assign w_tile_wrap  = (tile_q == c_TILE_LAST);
  assign w_group_last = (group_q == (num_groups_i - 7'd1));

  always_comb begin
    row_d   = row_q;
    tile_d  = tile_q;
    group_d = group_q;
    cf_d    = cf_q;
    if (clear_i) begin
      row_d   = '0;
      tile_d  = '0;
      group_d = '0;
      cf_d    = 7'd1;
    end else if (advance_i) begin
      if (!w_row_wrap) begin
        row_d = row_q + 9'd1;
      end else begin
        row_d = '0;
        if (!w_tile_wrap) begin
          tile_d = tile_q + 5'd1;
        end else begin
          tile_d  = '0;
          group_d = group_q + 7'd1;
          cf_d    = cf_q + 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      tile_q  <= '0;
      group_q <= '0;
      cf_q    <= '0;
    end else begin
      row_q   <= row_d;
      tile_q  <= tile_d;
      group_q <= group_d;
      cf_q    <= cf_d;
    end
  end

  assign row_o          = row_q;
  assign tile_o         = tile_q;
  assign count_filter_o = cf_q;
  assign row_wrap_o     = w_row_wrap;
  assign tile_wrap_o    = w_row_wrap & w_tile_wrap;
  assign last_o         = w_row_wrap & w_tile_wrap & w_group_last;

endmodule
`default_nettype wire

// File: rtl/ofm_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ofm_write_scheduler
//  Purpose  : Layer sequencer for the conv/maxpool output path. For every
//             window (row x column tile x filter group) it launches a
//             systolic compute pass, waits for its completion, then issues a
//             write burst (one write pulse, one ofm_wr_en beat per channel)
//             followed by two idle cycles for the address controller.
//  Ports    : clk, rst_n           - clock, async active-low reset
//             start_i              - layer start, ignored while busy
//             wgt_size_i           - channels per burst (0 treated as 1)
//             num_groups_i         - filter groups in the layer
//             compute_done_i       - systolic window result ready
//             compute_start_o      - launch compute of current window
//             write_o              - burst start pulse
//             ofm_wr_en_o          - per-channel beat enable
//             channel_idx_o        - channel of current beat
//             count_filter_o       - group index + 1
//             row_cnt_o/tile_cnt_o - current row / column tile
//             busy_o, done_o       - layer status
//  Revision : 1.0 - initial release
// ============================================================================
module ofm_write_scheduler
  import ofm_write_scheduler_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int OFM_SIZE      = 32,
  parameter int STRIDE        = 2,
  parameter int ADDR_WIDTH    = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WSZ_W-1:0]   wgt_size_i,
  input  logic [GROUP_W-1:0] num_groups_i,
  input  logic               compute_done_i,
  output logic               compute_start_o,
  output logic               write_o,
  output logic               ofm_wr_en_o,
  output logic [WSZ_W-1:0]   channel_idx_o,
  output logic [GROUP_W-1:0] count_filter_o,
  output logic [ROW_W-1:0]   row_cnt_o,
  output logic [TILE_W-1:0]  tile_cnt_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int COL_TILES = col_tiles(OFM_SIZE, SYSTOLIC_SIZE, STRIDE);

  // Reject configurations the scheduler cannot represent.
  if (ADDR_WIDTH < 1 || (STRIDE != 1 && STRIDE != 2) ||
      OFM_SIZE < 1 || OFM_SIZE > 512 || COL_TILES > 32) begin : g_param_check
    $error("ofm_write_scheduler: unsupported parameter combination");
  end

  sched_state_e       state_q;
  logic [WSZ_W-1:0]   wsz_l_q;
  logic [GROUP_W-1:0] num_groups_l_q;
  logic               settle_q;
  logic               compute_start_q;
  logic               write_q;
  logic               ofm_wr_en_q;
  logic [WSZ_W-1:0]   channel_idx_q;
  logic               busy_q;
  logic               done_q;

  logic w_clear;
  logic w_advance;
  logic w_last;
  logic w_last_beat;
  logic w_row_wrap;
  logic w_tile_wrap;

  assign w_clear     = (state_q == ST_IDLE) && start_i;
  assign w_last_beat = (channel_idx_q == (wsz_l_q - 5'd1));
  // Counters step on the second settle cycle, except after the final
  // window, so the group counter never runs past the layer.
  assign w_advance   = (state_q == ST_SETTLE) && settle_q && !w_last;

  sched_loop_counter #(
    .ROWS  (OFM_SIZE),
    .TILES (COL_TILES)
  ) u_loop_counter (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_i        (w_clear),
    .advance_i      (w_advance),
    .num_groups_i   (num_groups_l_q),
    .row_o          (row_cnt_o),
    .tile_o         (tile_cnt_o),
    .count_filter_o (count_filter_o),
    .row_wrap_o     (w_row_wrap),
    .tile_wrap_o    (w_tile_wrap),
    .last_o         (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      wsz_l_q         <= '0;
      num_groups_l_q  <= '0;
      settle_q        <= 1'b0;
      compute_start_q <= 1'b0;
      write_q         <= 1'b0;
      ofm_wr_en_q     <= 1'b0;
      channel_idx_q   <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      compute_start_q <= 1'b0;
      write_q         <= 1'b0;
      done_q          <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            wsz_l_q        <= (wgt_size_i == '0) ? 5'd1 : wgt_size_i;
            num_groups_l_q <= num_groups_i;
            busy_q         <= 1'b1;
            if (num_groups_i == '0) begin
              state_q <= ST_FINISH;
            end else begin
              state_q         <= ST_COMPUTE;
              compute_start_q <= 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (compute_done_i) begin
            state_q       <= ST_WRITE;
            write_q       <= 1'b1;
            ofm_wr_en_q   <= 1'b1;
            channel_idx_q <= '0;
          end
        end
        ST_WRITE: begin
          if (w_last_beat) begin
            state_q       <= ST_SETTLE;
            ofm_wr_en_q   <= 1'b0;
            channel_idx_q <= '0;
            settle_q      <= 1'b0;
          end else begin
            channel_idx_q <= channel_idx_q + 5'd1;
          end
        end
        ST_SETTLE: begin
          if (!settle_q) begin
            settle_q <= 1'b1;
          end else begin
            settle_q <= 1'b0;
            if (w_last) begin
              state_q <= ST_FINISH;
            end else begin
              state_q         <= ST_COMPUTE;
              compute_start_q <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign compute_start_o = compute_start_q;
  assign write_o         = write_q;
  assign ofm_wr_en_o     = ofm_wr_en_q;
  assign channel_idx_o   = channel_idx_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ofm_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ofm_write_scheduler
//  Purpose  : Scoreboard bench for ofm_write_scheduler. Two instances share
//             inputs: the default geometry (OFM 32, SYS 16) and a small one
//             (OFM 4, SYS 4). sel picks which one receives start and which
//             one the monitor watches.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ofm_write_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       compute_done_i = 1'b0;
  logic [4:0] wgt_size_i = '0;
  logic [6:0] num_groups_i = '0;
  logic       sel = 1'b0;

  always #5 clk = ~clk;

  logic start_big, start_small;
  assign start_big   = start_i & ~sel;
  assign start_small = start_i & sel;

  logic       b_cs, b_wr, b_en, b_busy, b_done;
  logic [4:0] b_ch, b_tile;
  logic [6:0] b_cf;
  logic [8:0] b_row;
  logic       s_cs, s_wr, s_en, s_busy, s_done;
  logic [4:0] s_ch, s_tile;
  logic [6:0] s_cf;
  logic [8:0] s_row;

  ofm_write_scheduler #(
    .SYSTOLIC_SIZE(16), .OFM_SIZE(32), .STRIDE(2), .ADDR_WIDTH(14)
  ) u_dut_big (
    .clk(clk), .rst_n(rst_n), .start_i(start_big), .wgt_size_i(wgt_size_i),
    .num_groups_i(num_groups_i), .compute_done_i(compute_done_i),
    .compute_start_o(b_cs), .write_o(b_wr), .ofm_wr_en_o(b_en),
    .channel_idx_o(b_ch), .count_filter_o(b_cf), .row_cnt_o(b_row),
    .tile_cnt_o(b_tile), .busy_o(b_busy), .done_o(b_done)
  );

  ofm_write_scheduler #(
    .SYSTOLIC_SIZE(4), .OFM_SIZE(4), .STRIDE(2), .ADDR_WIDTH(14)
  ) u_dut_small (
    .clk(clk), .rst_n(rst_n), .start_i(start_small), .wgt_size_i(wgt_size_i),
    .num_groups_i(num_groups_i), .compute_done_i(compute_done_i),
    .compute_start_o(s_cs), .write_o(s_wr), .ofm_wr_en_o(s_en),
    .channel_idx_o(s_ch), .count_filter_o(s_cf), .row_cnt_o(s_row),
    .tile_cnt_o(s_tile), .busy_o(s_busy), .done_o(s_done)
  );

  logic       m_cs, m_wr, m_en, m_busy, m_done;
  logic [4:0] m_ch, m_tile;
  logic [6:0] m_cf;
  logic [8:0] m_row;
  assign m_cs   = sel ? s_cs   : b_cs;
  assign m_wr   = sel ? s_wr   : b_wr;
  assign m_en   = sel ? s_en   : b_en;
  assign m_busy = sel ? s_busy : b_busy;
  assign m_done = sel ? s_done : b_done;
  assign m_ch   = sel ? s_ch   : b_ch;
  assign m_tile = sel ? s_tile : b_tile;
  assign m_cf   = sel ? s_cf   : b_cf;
  assign m_row  = sel ? s_row  : b_row;

  logic [30:0] b_all, s_all;
  assign b_all = {b_cs, b_wr, b_en, b_ch, b_cf, b_row, b_tile, b_busy, b_done};
  assign s_all = {s_cs, s_wr, s_en, s_ch, s_cf, s_row, s_tile, s_busy, s_done};

  typedef struct {
    int row;
    int tile;
    int cf;
    int nb;
  } burst_t;

  burst_t exp_q[$];
  burst_t cur;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  n_wr = 0, n_beat = 0, n_cs = 0, n_done = 0;
  int  last_wr = -1;
  int  exp_spacing = 0;
  int  beat_cnt = 0;
  bit  in_burst = 1'b0;
  int  pend = 0;
  bit  spur_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected burst per write pulse and checks every beat.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (m_wr) begin
        n_wr++;
        if (exp_spacing != 0 && last_wr >= 0)
          check("write spacing", cyc - last_wr, exp_spacing);
        last_wr = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected write: got write pulse, expected none (t=%0t)", $time);
        end else begin
          cur = exp_q.pop_front();
          check("burst row_cnt", int'(m_row), cur.row);
          check("burst tile_cnt", int'(m_tile), cur.tile);
          check("burst count_filter", int'(m_cf), cur.cf);
        end
        in_burst = 1'b1;
        beat_cnt = 0;
      end
      if (m_en) begin
        check("beat channel_idx", int'(m_ch), beat_cnt);
        beat_cnt++;
        n_beat++;
      end else if (in_burst) begin
        check("burst length", beat_cnt, cur.nb);
        in_burst = 1'b0;
      end
      if (m_cs) n_cs++;
      if (m_done) begin
        n_done++;
        check("bursts outstanding at done", exp_q.size(), 0);
      end
    end
  end

  // Systolic-array model: compute_done three negedges after compute_start,
  // optionally a spurious compute_done during the first write beat.
  initial begin
    forever begin
      @(negedge clk);
      compute_done_i = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) compute_done_i = 1'b1;
        end
        if (m_cs) pend = 3;
        if (spur_en && m_wr) compute_done_i = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_wr = 0; n_beat = 0; n_cs = 0; n_done = 0; last_wr = -1;
  endtask

  task automatic push_layer(input int ofm, input int tiles, input int wsz, input int ng);
    burst_t b;
    for (int g = 0; g < ng; g++)
      for (int t = 0; t < tiles; t++)
        for (int r = 0; r < ofm; r++) begin
          b.row = r; b.tile = t; b.cf = g + 1; b.nb = (wsz == 0) ? 1 : wsz;
          exp_q.push_back(b);
        end
  endtask

  task automatic start_layer(input int wsz, input int ng);
    tick();
    wgt_size_i = 5'(wsz);
    num_groups_i = 7'(ng);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("busy after start", int'(m_busy), 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int k;
    d0 = n_done;
    k = 0;
    while (n_done == d0 && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (n_done == d0) begin
      errors++;
      $display("FAIL %s: got no done within %0d cycles, expected done", name, budget);
    end
  endtask

  task automatic finish_bench();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    finish_bench();
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset outputs big", int'(b_all), 0);
    check("reset outputs small", int'(s_all), 0);
    rst_n = 1'b1;
    tick();

    // 1: default geometry, 32 rows x 4 tiles, 4 channels per burst
    sel = 1'b0;
    clear_counts();
    exp_spacing = 4 + 2 + 4;
    push_layer(32, 4, 4, 1);
    start_layer(4, 1);
    wait_done("T1 done", 3000);
    tick();
    check("T1 writes", n_wr, 128);
    check("T1 beats", n_beat, 512);
    check("T1 compute_starts", n_cs, 128);
    check("T1 done pulses", n_done, 1);
    check("T1 busy after done", int'(m_busy), 0);

    // 2: small geometry, 2 groups of 4 rows x 2 tiles, 3 channels
    sel = 1'b1;
    clear_counts();
    exp_spacing = 3 + 2 + 4;
    push_layer(4, 2, 3, 2);
    start_layer(3, 2);
    wait_done("T2 done", 500);
    tick();
    check("T2 writes", n_wr, 16);
    check("T2 beats", n_beat, 48);
    check("T2 done pulses", n_done, 1);

    // 3: wgt_size 0 behaves as a single channel
    clear_counts();
    exp_spacing = 1 + 2 + 4;
    push_layer(4, 2, 0, 1);
    start_layer(0, 1);
    wait_done("T3 done", 300);
    tick();
    check("T3 writes", n_wr, 8);
    check("T3 beats", n_beat, 8);

    // 4: zero groups finishes straight away
    clear_counts();
    exp_spacing = 0;
    tick();
    wgt_size_i = 5'd3;
    num_groups_i = 7'd0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("T4 busy one cycle after start", int'(m_busy), 1);
    check("T4 done one cycle after start", int'(m_done), 0);
    tick();
    check("T4 done two cycles after start", int'(m_done), 1);
    check("T4 busy with done", int'(m_busy), 0);
    repeat (3) tick();
    check("T4 compute_starts", n_cs, 0);
    check("T4 writes", n_wr, 0);
    check("T4 done pulses", n_done, 1);

    // 5: start while busy and spurious compute_done are ignored
    clear_counts();
    exp_spacing = 3 + 2 + 4;
    spur_en = 1'b1;
    push_layer(4, 2, 3, 2);
    start_layer(3, 2);
    repeat (20) tick();
    wgt_size_i = 5'd7;
    num_groups_i = 7'd5;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("T5 busy mid-layer", int'(m_busy), 1);
    wait_done("T5 done", 500);
    tick();
    spur_en = 1'b0;
    check("T5 writes", n_wr, 16);
    check("T5 beats", n_beat, 48);
    check("T5 done pulses", n_done, 1);

    // 6: asynchronous reset during the second write beat, then a clean layer
    clear_counts();
    exp_spacing = 0;
    push_layer(4, 2, 3, 1);
    start_layer(3, 1);
    begin
      int k;
      k = 0;
      while (!m_wr && k < 50) begin
        tick();
        k++;
      end
      check("T6 write seen before reset", int'(m_wr), 1);
    end
    @(posedge clk);
    #2;
    check("T6 channel_idx at beat 2", int'(m_ch), 1);
    exp_q.delete();
    in_burst = 1'b0;
    rst_n = 1'b0;
    #1;
    check("T6 async reset outputs small", int'(s_all), 0);
    check("T6 async reset outputs big", int'(b_all), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_counts();
    exp_spacing = 3 + 2 + 4;
    push_layer(4, 2, 3, 1);
    start_layer(3, 1);
    check("T6 restart row", int'(m_row), 0);
    check("T6 restart tile", int'(m_tile), 0);
    check("T6 restart count_filter", int'(m_cf), 1);
    wait_done("T6 done", 300);
    tick();
    check("T6 writes", n_wr, 8);
    check("T6 beats", n_beat, 24);

    finish_bench();
  end

endmodule
`default_nettype wire
